// File: rtl/riscv_defines.sv
// Shared encodings for the DIFT execute-stage tag unit: propagation modes,
// exception FSM states and violation cause bit positions.
package riscv_defines;

  typedef enum logic [1:0] {
    MODE_AND  = 2'd0,
    MODE_OR   = 2'd1,
    MODE_CLR  = 2'd2,
    MODE_KEEP = 2'd3
  } tag_mode_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } exc_state_e;

  localparam int CAUSE_S1 = 0;
  localparam int CAUSE_S2 = 1;
  localparam int CAUSE_D  = 2;

endpackage

// File: rtl/riscv_tag_prop_param.sv
// Combines two operand tags according to the propagation mode and reports
// whether the result carries any taint.
module riscv_tag_prop_param
  import riscv_defines::*;
#(
  parameter int TAG_WIDTH = 1
) (
  input  logic [1:0]           mode_i,
  input  logic [TAG_WIDTH-1:0] tag_a_i,
  input  logic [TAG_WIDTH-1:0] tag_b_i,
  output logic [TAG_WIDTH-1:0] res_o,
  output logic                 prop_en_o,
  output logic                 taint_o
);

  always_comb begin
    res_o = '0;
    case (tag_mode_e'(mode_i))
      MODE_AND:  res_o = tag_a_i & tag_b_i;
      MODE_OR:   res_o = tag_a_i | tag_b_i;
      MODE_CLR:  res_o = '0;
      MODE_KEEP: res_o = tag_a_i;
      default:   res_o = '0;
    endcase
  end

  assign prop_en_o = (tag_mode_e'(mode_i) != MODE_KEEP);
  assign taint_o   = |res_o;

endmodule

// File: rtl/riscv_dift_ex_tag_unit.sv
// DIFT execute-stage tag unit: tag propagation, tag-check exceptions and
// load rs1 tag capture. DIFT_VIOL_CNT_EN adds a saturating violation counter.
module riscv_dift_ex_tag_unit
  import riscv_defines::*;
#(
  parameter int TAG_WIDTH = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [1:0]           mode_i,
  input  logic [TAG_WIDTH-1:0] tag_a_i,
  input  logic [TAG_WIDTH-1:0] tag_b_i,
  input  logic [TAG_WIDTH-1:0] tag_c_i,
  input  logic                 check_s1_i,
  input  logic                 check_s2_i,
  input  logic                 check_d_i,
  input  logic                 register_set_i,
  input  logic                 memory_set_i,
  input  logic                 is_load_i,
  input  logic                 is_store_i,
  input  logic                 rf_we_i,
  input  logic [4:0]           waddr_i,
  input  logic                 cmp_result_i,
  output logic [TAG_WIDTH-1:0] rf_tag_o,
  output logic [TAG_WIDTH-1:0] mem_tag_o,
  output logic [TAG_WIDTH-1:0] pc_tag_o,
  output logic                 rf_tag_we_o,
  output logic                 mem_tag_we_o,
  output logic                 pc_tag_we_o,
  output logic [4:0]           rf_tag_waddr_o,
  output logic [TAG_WIDTH-1:0] load_rs1_tag_o,
  output logic                 exc_valid_o,
  output logic [2:0]           exc_cause_o,
  output logic [4:0]           exc_waddr_o,
  input  logic                 exc_ack_i,
`ifdef DIFT_VIOL_CNT_EN
  input  logic                 cnt_clr_i,
`endif
  output logic [CNT_WIDTH-1:0] viol_cnt_o
);

  localparam logic [TAG_WIDTH-1:0] TAG_ONES = {TAG_WIDTH{1'b1}};

  logic [TAG_WIDTH-1:0] res;
  logic                 prop_en;
  logic                 taint;
  logic                 transfer;
  logic                 c_tainted;
  logic [2:0]           viol;
  exc_state_e           state;

  riscv_tag_prop_param #(
    .TAG_WIDTH (TAG_WIDTH)
  ) u_prop (
    .mode_i    (mode_i),
    .tag_a_i   (tag_a_i),
    .tag_b_i   (tag_b_i),
    .res_o     (res),
    .prop_en_o (prop_en),
    .taint_o   (taint)
  );

  assign ready_o  = (state == ST_IDLE);
  assign transfer = valid_i & ready_o;

  assign rf_tag_o       = register_set_i ? TAG_ONES : res;
  assign rf_tag_we_o    = transfer & rf_we_i & (register_set_i | prop_en);
  assign rf_tag_waddr_o = waddr_i;
  assign mem_tag_o      = memory_set_i ? TAG_ONES : res;
  assign mem_tag_we_o   = transfer & is_store_i & (memory_set_i | prop_en);

  // A tainted branch condition tag overrides the operand result on the PC.
  assign c_tainted   = |tag_c_i;
  assign pc_tag_we_o = cmp_result_i & (c_tainted | taint);
  assign pc_tag_o    = c_tainted ? tag_c_i : res;

  // Loads write their destination tag from memory later, so no d-check here.
  assign viol[CAUSE_D]  = check_d_i & ~is_load_i & (|rf_tag_o);
  assign viol[CAUSE_S2] = check_s2_i & (|tag_b_i);
  assign viol[CAUSE_S1] = check_s1_i & (|tag_a_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      exc_valid_o <= 1'b0;
      exc_cause_o <= '0;
      exc_waddr_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (transfer && (viol != 3'b000)) begin
            state       <= ST_PENDING;
            exc_valid_o <= 1'b1;
            exc_cause_o <= viol;
            exc_waddr_o <= waddr_i;
          end
        end
        ST_PENDING: begin
          if (exc_ack_i) begin
            state       <= ST_IDLE;
            exc_valid_o <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          exc_valid_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_rs1_tag_o <= '0;
    end else if (transfer && is_load_i) begin
      load_rs1_tag_o <= tag_a_i;
    end
  end

`ifdef DIFT_VIOL_CNT_EN
  logic [CNT_WIDTH-1:0] viol_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      viol_cnt_q <= '0;
    end else if (cnt_clr_i) begin
      viol_cnt_q <= '0;
    end else if (transfer && (viol != 3'b000) && (viol_cnt_q != {CNT_WIDTH{1'b1}})) begin
      viol_cnt_q <= viol_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign viol_cnt_o = viol_cnt_q;
`else
  assign viol_cnt_o = '0;
`endif

endmodule

// File: tb/tb_riscv_dift_ex_tag_unit.sv
// Randomized self-checking bench for riscv_dift_ex_tag_unit against a
// rule-level reference model; honours DIFT_VIOL_CNT_EN when defined.
module tb_riscv_dift_ex_tag_unit;

  localparam int TW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_i, ready_o;
  logic [1:0]    mode_i;
  logic [TW-1:0] tag_a_i, tag_b_i, tag_c_i;
  logic          check_s1_i, check_s2_i, check_d_i;
  logic          register_set_i, memory_set_i;
  logic          is_load_i, is_store_i, rf_we_i;
  logic [4:0]    waddr_i;
  logic          cmp_result_i;
  logic [TW-1:0] rf_tag_o, mem_tag_o, pc_tag_o;
  logic          rf_tag_we_o, mem_tag_we_o, pc_tag_we_o;
  logic [4:0]    rf_tag_waddr_o;
  logic [TW-1:0] load_rs1_tag_o;
  logic          exc_valid_o;
  logic [2:0]    exc_cause_o;
  logic [4:0]    exc_waddr_o;
  logic          exc_ack_i;
  logic          cnt_clr_i;
  logic [CW-1:0] viol_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  bit            m_pend;
  logic [2:0]    m_cause;
  logic [4:0]    m_waddr;
  logic [TW-1:0] m_ltag;
  int            m_cnt;

  always #5 clk = ~clk;

  riscv_dift_ex_tag_unit #(.TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .mode_i         (mode_i),
    .tag_a_i        (tag_a_i),
    .tag_b_i        (tag_b_i),
    .tag_c_i        (tag_c_i),
    .check_s1_i     (check_s1_i),
    .check_s2_i     (check_s2_i),
    .check_d_i      (check_d_i),
    .register_set_i (register_set_i),
    .memory_set_i   (memory_set_i),
    .is_load_i      (is_load_i),
    .is_store_i     (is_store_i),
    .rf_we_i        (rf_we_i),
    .waddr_i        (waddr_i),
    .cmp_result_i   (cmp_result_i),
    .rf_tag_o       (rf_tag_o),
    .mem_tag_o      (mem_tag_o),
    .pc_tag_o       (pc_tag_o),
    .rf_tag_we_o    (rf_tag_we_o),
    .mem_tag_we_o   (mem_tag_we_o),
    .pc_tag_we_o    (pc_tag_we_o),
    .rf_tag_waddr_o (rf_tag_waddr_o),
    .load_rs1_tag_o (load_rs1_tag_o),
    .exc_valid_o    (exc_valid_o),
    .exc_cause_o    (exc_cause_o),
    .exc_waddr_o    (exc_waddr_o),
    .exc_ack_i      (exc_ack_i),
`ifdef DIFT_VIOL_CNT_EN
    .cnt_clr_i      (cnt_clr_i),
`endif
    .viol_cnt_o     (viol_cnt_o)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] m_res();
    case (mode_i)
      2'd0:    return tag_a_i & tag_b_i;
      2'd1:    return tag_a_i | tag_b_i;
      2'd2:    return '0;
      default: return tag_a_i;
    endcase
  endfunction

  function automatic logic [TW-1:0] m_rf_tag();
    return register_set_i ? {TW{1'b1}} : m_res();
  endfunction

  function automatic logic [2:0] m_viol();
    logic [2:0] v;
    v[0] = check_s1_i && (tag_a_i != 0);
    v[1] = check_s2_i && (tag_b_i != 0);
    v[2] = check_d_i && !is_load_i && (m_rf_tag() != 0);
    return v;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_cause = '0; m_waddr = '0; m_ltag = '0; m_cnt = 0;
  endtask

  task automatic model_clock();
    bit xfer;
    xfer = valid_i && !m_pend;
    if (m_pend) begin
      if (exc_ack_i) m_pend = 0;
    end else if (xfer && m_viol() != 0) begin
      m_pend = 1; m_cause = m_viol(); m_waddr = waddr_i;
    end
    if (xfer && is_load_i) m_ltag = tag_a_i;
`ifdef DIFT_VIOL_CNT_EN
    if (cnt_clr_i) m_cnt = 0;
    else if (xfer && m_viol() != 0 && m_cnt < (1 << CW) - 1) m_cnt++;
`endif
  endtask

  task automatic check_comb();
    bit xfer, keep;
    logic [TW-1:0] res;
    xfer = valid_i && !m_pend;
    keep = (mode_i == 2'd3);
    res  = m_res();
    chk_val("ready",     32'(ready_o),      32'(!m_pend));
    chk_val("rf_tag",    32'(rf_tag_o),     32'(m_rf_tag()));
    chk_val("rf_we",     32'(rf_tag_we_o),  32'(xfer && rf_we_i && (register_set_i || !keep)));
    chk_val("rf_waddr",  32'(rf_tag_waddr_o), 32'(waddr_i));
    chk_val("mem_tag",   32'(mem_tag_o),    32'(memory_set_i ? {TW{1'b1}} : res));
    chk_val("mem_we",    32'(mem_tag_we_o), 32'(xfer && is_store_i && (memory_set_i || !keep)));
    chk_val("pc_tag",    32'(pc_tag_o),     32'(tag_c_i != 0 ? tag_c_i : res));
    chk_val("pc_we",     32'(pc_tag_we_o),  32'(cmp_result_i && (tag_c_i != 0 || res != 0)));
  endtask

  task automatic check_regs();
    chk_val("exc_valid", 32'(exc_valid_o), 32'(m_pend));
    if (m_pend) begin
      chk_val("exc_cause", 32'(exc_cause_o), 32'(m_cause));
      chk_val("exc_waddr", 32'(exc_waddr_o), 32'(m_waddr));
    end
    chk_val("load_tag",  32'(load_rs1_tag_o), 32'(m_ltag));
    chk_val("viol_cnt",  32'(viol_cnt_o), 32'(m_cnt));
  endtask

  // inputs must already be driven (at a falling edge) before calling
  task automatic step();
    #1;
    check_comb();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_regs();
  endtask

  task automatic clear_inputs();
    valid_i = 0; mode_i = 2'd0; tag_a_i = '0; tag_b_i = '0; tag_c_i = '0;
    check_s1_i = 0; check_s2_i = 0; check_d_i = 0;
    register_set_i = 0; memory_set_i = 0; is_load_i = 0; is_store_i = 0;
    rf_we_i = 0; waddr_i = '0; cmp_result_i = 0; exc_ack_i = 0; cnt_clr_i = 0;
  endtask

  task automatic randomize_inputs();
    valid_i        = ($urandom_range(0, 3) != 0);
    mode_i         = 2'($urandom_range(0, 3));
    tag_a_i        = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom);
    tag_b_i        = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom);
    tag_c_i        = ($urandom_range(0, 1) == 0) ? '0 : TW'($urandom);
    check_s1_i     = ($urandom_range(0, 3) == 0);
    check_s2_i     = ($urandom_range(0, 3) == 0);
    check_d_i      = ($urandom_range(0, 3) == 0);
    register_set_i = ($urandom_range(0, 3) == 0);
    memory_set_i   = ($urandom_range(0, 3) == 0);
    is_load_i      = ($urandom_range(0, 3) == 0);
    is_store_i     = ($urandom_range(0, 2) == 0);
    rf_we_i        = ($urandom_range(0, 1) == 1);
    waddr_i        = 5'($urandom);
    cmp_result_i   = ($urandom_range(0, 1) == 1);
    exc_ack_i      = ($urandom_range(0, 2) == 0);
    cnt_clr_i      = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk_val("rst_exc_valid", 32'(exc_valid_o), 32'(0));
    chk_val("rst_exc_cause", 32'(exc_cause_o), 32'(0));
    chk_val("rst_exc_waddr", 32'(exc_waddr_o), 32'(0));
    chk_val("rst_load_tag",  32'(load_rs1_tag_o), 32'(0));
    chk_val("rst_cnt",       32'(viol_cnt_o), 32'(0));
    rst_n = 1;

    // AND propagation into the register file
    valid_i = 1; mode_i = 2'd0; tag_a_i = 4'b1100; tag_b_i = 4'b1010; rf_we_i = 1; waddr_i = 5'd7;
    #1;
    chk_val("and_rf_tag", 32'(rf_tag_o), 32'(4'b1000));
    chk_val("and_rf_we",  32'(rf_tag_we_o), 32'(1));
    step();

    // KEEP mode writes only when force-set
    clear_inputs();
    valid_i = 1; mode_i = 2'd3; rf_we_i = 1; register_set_i = 1; tag_a_i = 4'h2;
    #1;
    chk_val("keep_set_tag", 32'(rf_tag_o), 32'(4'hF));
    chk_val("keep_set_we",  32'(rf_tag_we_o), 32'(1));
    step();
    register_set_i = 0;
    #1;
    chk_val("keep_noset_we", 32'(rf_tag_we_o), 32'(0));
    step();

    // branch tag from operands when condition tag clean
    clear_inputs();
    valid_i = 1; mode_i = 2'd1; tag_a_i = 4'd0; tag_b_i = 4'd2; cmp_result_i = 1;
    #1;
    chk_val("br_pc_we",  32'(pc_tag_we_o), 32'(1));
    chk_val("br_pc_tag", 32'(pc_tag_o), 32'(2));
    step();
    cmp_result_i = 0;
    #1;
    chk_val("br_nt_pc_we", 32'(pc_tag_we_o), 32'(0));
    step();

    // tainted load destination must not raise a d-check exception
    clear_inputs();
    valid_i = 1; is_load_i = 1; check_d_i = 1; rf_we_i = 1; mode_i = 2'd1; tag_a_i = 4'h3;
    step();
    chk_val("load_no_exc", 32'(exc_valid_o), 32'(0));
    chk_val("load_tag_cap", 32'(load_rs1_tag_o), 32'(4'h3));

    // s1 violation: pending for three cycles until acknowledged
    clear_inputs();
    valid_i = 1; check_s1_i = 1; tag_a_i = 4'h1; waddr_i = 5'd9;
    step();
    chk_val("s1_exc_valid", 32'(exc_valid_o), 32'(1));
    chk_val("s1_cause",     32'(exc_cause_o), 32'(3'b001));
    chk_val("s1_ready",     32'(ready_o), 32'(0));
    valid_i = 1; check_s1_i = 0;
    step();
    step();
    exc_ack_i = 1;
    step();
    chk_val("s1_ack_ready", 32'(ready_o), 32'(1));
    exc_ack_i = 0; valid_i = 0;
    step();

    // reset while an exception is pending discards it immediately
    valid_i = 1; check_s2_i = 1; tag_b_i = 4'h4;
    step();
    clear_inputs();
    #2 rst_n = 0;
    #1;
    chk_val("rst_pend_valid", 32'(exc_valid_o), 32'(0));
    chk_val("rst_pend_ready", 32'(ready_o), 32'(1));
    model_reset();
    @(negedge clk);
    rst_n = 1;

`ifdef DIFT_VIOL_CNT_EN
    // saturation, then clear winning over a simultaneous violation
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      valid_i = 1; check_s1_i = 1; tag_a_i = 4'h8;
      step();
      exc_ack_i = 1; valid_i = 0;
      step();
    end
    chk_val("cnt_sat", 32'(viol_cnt_o), 32'(3));
    clear_inputs();
    valid_i = 1; check_s1_i = 1; tag_a_i = 4'h8; cnt_clr_i = 1;
    step();
    chk_val("cnt_clr_wins", 32'(viol_cnt_o), 32'(0));
    clear_inputs();
    exc_ack_i = 1;
    step();
`endif

    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
